lfsr_rng_arbiter: RTL
=====================

Name: lfsr_rng_arbiter

Overview:
Owns a Fibonacci LFSR and shares it, as a pseudo-random word source, between 2 requesters under round-robin arbitration. For each granted request the block steps the LFSR W times, one step per cycle, and serially assembles a W-bit word from the LFSR output bit. It also sequences seeding. Sits between the LFSR datapath and consumers such as test-pattern generators and scramblers.

Parameters:
N, 8, LFSR width (state vector Q[N:1], bit positions 1..N).
W, 8, output word width in bits, 1..32.
TAP_MASK, 8'hB8, feedback taps; mask bit i-1 set means position i is XORed into feedback. The default is max-length taps 8,6,5,4 (period 255).

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
req  in  2  request per requester, level
seed_load  in  1  load seed (single-cycle pulse)
seed  in  N  seed value
gnt  out  2  one-hot grant; zero when idle
rdata  out  W  random word, valid with rvalid
rvalid  out  1  one-cycle word-valid strobe
busy  out  1  high in SHIFT or DONE
lfsr_state  out  N  current LFSR state Q[N:1]
period_wrap  out  1  see Optional Feature

Behaviour:
- Reset (async, reset_n low): lfsr_state=1 (Q[1]=1), gnt=0, rvalid=0, rdata=0, busy=0, period_wrap=0. The round-robin pointer favours requester 0 first. The FSM enters IDLE.
- LFSR step: fb = XOR of Q[i] for each TAP_MASK bit set; Q_next = {Q[N-1:1], fb}, i.e. Q[1] takes fb and every other bit shifts up one position. Output bit = Q[N] before the step.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE:
  - seed_load=1: load seed. A seed of 0 loads 1 instead, because the all-zero state locks up. Stay in IDLE and ignore req this cycle.
  - Otherwise, if any req is high: grant the highest-priority requester. Priority is round-robin: the requester not granted last wins when both are high.
  - On grant: set gnt one-hot, clear the bit counter, go to SHIFT.
  - No req: the LFSR holds.
- SHIFT:
  - Each cycle: rdata_shift = {rdata_shift[W-2:0], Q[N]}, LFSR steps, counter increments.
  - After the W-th step, go to DONE.
  - req and seed_load are ignored. Dropping req does not abort the operation.
- DONE: rvalid=1 for exactly this cycle; rdata holds the word (first bit in MSB); gnt held. Next cycle: gnt=0, rvalid=0, pointer updated, IDLE.
- Latency: gnt rises at edge k. The LFSR steps at edges k+1..k+W. rvalid is high in the cycle following edge k+W+1 and deasserts at edge k+W+2. Minimum request-to-request spacing is W+3 cycles.
- rdata holds its last value outside DONE; only rvalid qualifies it.
- Both req high continuously: grants alternate 0,1,0,1.
- Reset mid-operation: immediate abort, all outputs return to reset values, no rvalid.
- lfsr_state is never 0 after reset.

Optional Feature:
Macro LFSR_PERIOD_CHECK_EN.
- Defined: a period counter (N bits) clears on reset and on seed load, and increments on each step. When the state after a step equals the most recent seed (1 after reset), period_wrap pulses for one cycle and the counter clears. When the count reaches 2^N-1 without a wrap, period_wrap stays low and a sticky internal flag period_err is set for the bench to probe.
- Undefined: period_wrap is tied 0 and there is no counter logic.

Decomposition:
- Shared package lfsr_pkg: FSM state encoding (IDLE/SHIFT/DONE), default TAP_MASK constants per width 3..32 from the max-length tap table, requester-count constant 2.
- One sub-module, lfsr_core: the LFSR state register plus feedback, with load and step enables. The controller instantiates it.

Test Plan:
- Reset then idle: lfsr_state=0x01, gnt=0, rvalid=0, busy=0. After 20 cycles with no req, state still 0x01.
- req=2'b01 after reset (N=8, W=8): gnt=01 for 10 cycles. rvalid once, with rdata=0x01. Final lfsr_state=0x1C (steps 02,04,08,11,23,47,8E,1C).
- req=2'b11 held: grants alternate 01,10,01,10. Consecutive rvalid strobes are 11 cycles apart. Every word matches the reference model.
- seed_load with seed=0x00 in IDLE: lfsr_state=0x01. seed_load during SHIFT is ignored: state continues the sequence.
- reset_n low at the 4th SHIFT cycle: outputs go to reset values immediately. The next request behaves as after a fresh reset (rdata=0x01).
- With LFSR_PERIOD_CHECK_EN: seed 0x01, requests run continuously. period_wrap pulses exactly once per 255 steps and period_err stays 0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared FSM encoding, requester count and max-length LFSR tap table
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned REQ_CNT = 2;

  // Mask bit i-1 selects position i; entries are maximal-length tap sets.
  function automatic logic [31:0] default_taps(input int unsigned n);
    logic [31:0] t;
    case (n)
      3:       t = 32'h0000_0006;
      4:       t = 32'h0000_000C;
      5:       t = 32'h0000_0014;
      6:       t = 32'h0000_0030;
      7:       t = 32'h0000_0060;
      8:       t = 32'h0000_00B8;
      9:       t = 32'h0000_0110;
      10:      t = 32'h0000_0240;
      11:      t = 32'h0000_0500;
      12:      t = 32'h0000_0829;
      13:      t = 32'h0000_100D;
      14:      t = 32'h0000_2015;
      15:      t = 32'h0000_6000;
      16:      t = 32'h0000_D008;
      17:      t = 32'h0001_2000;
      18:      t = 32'h0002_0400;
      19:      t = 32'h0004_0023;
      20:      t = 32'h0009_0000;
      21:      t = 32'h0014_0000;
      22:      t = 32'h0030_0000;
      23:      t = 32'h0042_0000;
      24:      t = 32'h00E1_0000;
      25:      t = 32'h0120_0000;
      26:      t = 32'h0200_0023;
      27:      t = 32'h0400_0013;
      28:      t = 32'h0900_0000;
      29:      t = 32'h1400_0000;
      30:      t = 32'h2000_0029;
      31:      t = 32'h4800_0000;
      32:      t = 32'h8020_0003;
      default: t = 32'h0000_00B8;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - Fibonacci LFSR state register with load and step enables
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned  N        = 8,
  parameter logic [N-1:0] TAP_MASK = N'(default_taps(N))
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [N-1:0] load_val_i,
  input  logic         step_i,
  output logic [N-1:0] state_o,
  output logic         out_bit_o
);

  logic [N-1:0] state_q, state_d;
  logic         fb;

  assign fb = ^(state_q & TAP_MASK);

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = load_val_i;
    end else if (step_i) begin
      state_d = {state_q[N-2:0], fb};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= N'(1);
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o   = state_q;
  assign out_bit_o = state_q[N-1];

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// rtl/lfsr_rng_arbiter.sv - round-robin shared LFSR word generator with seeding
// Optional LFSR_PERIOD_CHECK_EN adds a period counter driving period_wrap.
module lfsr_rng_arbiter
  import lfsr_pkg::*;
#(
  parameter int unsigned  N        = 8,
  parameter int unsigned  W        = 8,
  parameter logic [N-1:0] TAP_MASK = N'(8'hB8)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [REQ_CNT-1:0] req,
  input  logic               seed_load,
  input  logic [N-1:0]       seed,
  output logic [REQ_CNT-1:0] gnt,
  output logic [W-1:0]       rdata,
  output logic               rvalid,
  output logic               busy,
  output logic [N-1:0]       lfsr_state,
  output logic               period_wrap
);

  localparam int unsigned CW = $clog2(W + 1);

  state_e             state_q, state_d;
  logic [REQ_CNT-1:0] gnt_q, gnt_d;
  logic [W-1:0]       rdata_q, rdata_d;
  logic [W-1:0]       shift_q, shift_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               rvalid_q, rvalid_d;
  logic               busy_q, busy_d;
  logic               last_q, last_d;
  logic               load, step, out_bit;
  logic [N-1:0]       load_val;

  // The all-zero state is a lock-up point, so a zero seed becomes 1.
  assign load_val = (seed == '0) ? N'(1) : seed;

  lfsr_core #(
    .N        (N),
    .TAP_MASK (TAP_MASK)
  ) u_core (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (load),
    .load_val_i (load_val),
    .step_i     (step),
    .state_o    (lfsr_state),
    .out_bit_o  (out_bit)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rdata_d  = rdata_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    rvalid_d = 1'b0;
    busy_d   = busy_q;
    last_d   = last_q;
    load     = 1'b0;
    step     = 1'b0;
    case (state_q)
      IDLE: begin
        if (seed_load) begin
          load = 1'b1;
        end else if (|req) begin
          // last_q holds the index granted last; the other requester wins a tie.
          if (req[0] && (!req[1] || last_q)) gnt_d = 2'b01;
          else                               gnt_d = 2'b10;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CW'(W)) begin
          rdata_d  = shift_q;
          rvalid_d = 1'b1;
          state_d  = DONE;
        end else begin
          step    = 1'b1;
          shift_d = W'({shift_q, out_bit});
          cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        last_d  = gnt_q[1];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rdata_q  <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rdata_q  <= rdata_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
    end
  end

  assign gnt    = gnt_q;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign busy   = busy_q;

`ifdef LFSR_PERIOD_CHECK_EN
  logic [N-1:0] pcnt_q, pcnt_inc, seed_ref_q;
  logic         step_q, wrap_q, period_err_q;
  logic         period_err;

  assign pcnt_inc = pcnt_q + N'(1);

  // Evaluated the cycle after a step, against the state that step produced.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q       <= '0;
      seed_ref_q   <= N'(1);
      step_q       <= 1'b0;
      wrap_q       <= 1'b0;
      period_err_q <= 1'b0;
    end else begin
      step_q <= step;
      wrap_q <= 1'b0;
      if (load) begin
        pcnt_q     <= '0;
        seed_ref_q <= load_val;
      end else if (step_q) begin
        if (lfsr_state == seed_ref_q) begin
          pcnt_q <= '0;
          wrap_q <= 1'b1;
        end else begin
          pcnt_q <= pcnt_inc;
          if (&pcnt_inc) period_err_q <= 1'b1;
        end
      end
    end
  end

  assign period_err  = period_err_q;
  assign period_wrap = wrap_q;
`else
  assign period_wrap = 1'b0;
`endif

endmodule
